axis_slave_rx: RTL and testbench

- AXI4-Stream receiver: the input-side counterpart to the accelerator's AXIS master output stage.
- Accepts ifmap/weight/bias beats from the DMA on S_AXIS, masks byte lanes by TSTRB and buffers beats in a first-word-fall-through FIFO.
- Frames each transfer as a packet of a programmed beat count and flags length mismatches against TLAST.
- Feeds the data path's load logic via a simple pop interface.

---
 rtl/axis_slave_rx.sv | 181 ++++++++++++++++++
 tb/tb_axis_slave_rx.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_slave_rx.sv
// AXI4-Stream receiver: strobe-masks incoming beats into a first-word-fall-through
// FIFO, frames packets by programmed length and/or TLAST, and flags length mismatches.
module axis_slave_rx #(
    parameter int FIFO_DEPTH           = 16,
    parameter int C_S_AXIS_TDATA_WIDTH = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    output logic                                  S_AXIS_TREADY,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]       S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]     S_AXIS_TSTRB,
    input  logic                                  S_AXIS_TLAST,
    input  logic                                  S_AXIS_TVALID,
    input  logic                                  rx_en,
    input  logic                                  rx_clear,
    input  logic [15:0]                           expected_beats,
    input  logic                                  rd_en,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]       rd_data,
    output logic                                  rd_last,
    output logic                                  rd_valid,
    output logic                                  fifo_empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]       fifo_count,
    output logic [15:0]                           beat_count,
    output logic                                  packet_done,
    output logic                                  len_error,
    output logic [1:0]                            rx_state_o
);

    localparam int DW    = C_S_AXIS_TDATA_WIDTH;
    localparam int SW    = DW / 8;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECEIVE = 2'd1,
        DONE    = 2'd2
    } rx_state_e;

    rx_state_e         state_q, state_d;
    logic [15:0]       beat_count_q, beat_count_d;
    logic              packet_done_q, packet_done_d;
    logic              len_error_q, len_error_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DW:0]       mem_q [FIFO_DEPTH];

    logic              full;
    logic              empty;
    logic              tready;
    logic              accept;
    logic              pop;
    logic [DW-1:0]     masked_data;
    logic [16:0]       beat_next;
    logic              exp_nonzero;
    logic              hit_len;
    logic              early_last;
    logic [DW:0]       head;

    // Handshake: a beat transfers on a rising edge where TVALID and TREADY are
    // both high; TREADY depends only on registered state, the fill level and
    // rx_clear, never on TVALID, so the sender may hold TVALID indefinitely.
    assign full   = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty  = (count_q == '0);
    assign tready = (state_q == RECEIVE) && !full && !rx_clear;
    assign accept = S_AXIS_TVALID && tready;
    assign pop    = rd_en && !empty && !rx_clear;

    always_comb begin
        masked_data = '0;
        for (int i = 0; i < SW; i++) begin
            masked_data[i*8 +: 8] = S_AXIS_TSTRB[i] ? S_AXIS_TDATA[i*8 +: 8] : 8'h00;
        end
    end

    // Framing decisions look at the count as it will be after this beat.
    assign beat_next   = {1'b0, beat_count_q} + 17'd1;
    assign exp_nonzero = (expected_beats != 16'd0);
    assign hit_len     = exp_nonzero && (beat_next == {1'b0, expected_beats});
    assign early_last  = S_AXIS_TLAST && exp_nonzero && (beat_next < {1'b0, expected_beats});

    always_comb begin
        state_d       = state_q;
        beat_count_d  = beat_count_q;
        packet_done_d = 1'b0;
        len_error_d   = 1'b0;
        if (rx_clear) begin
            state_d      = IDLE;
            beat_count_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rx_en) begin
                        state_d      = RECEIVE;
                        beat_count_d = '0;
                    end
                end
                RECEIVE: begin
                    if (accept) begin
                        beat_count_d = beat_next[15:0];
                        if (S_AXIS_TLAST || hit_len) begin
                            state_d       = DONE;
                            packet_done_d = 1'b1;
                            len_error_d   = early_last || (hit_len && !S_AXIS_TLAST);
                        end
                    end
                end
                DONE: begin
                    if (!rx_en) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (rx_clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (accept) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({accept, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            beat_count_q  <= '0;
            packet_done_q <= 1'b0;
            len_error_q   <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            beat_count_q  <= beat_count_d;
            packet_done_q <= packet_done_d;
            len_error_q   <= len_error_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    // Storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= {S_AXIS_TLAST, masked_data};
        end
    end

    assign head          = mem_q[rd_ptr_q];
    assign rd_data       = empty ? '0 : head[DW-1:0];
    assign rd_last       = !empty && head[DW];
    assign rd_valid      = !empty;
    assign fifo_empty    = empty;
    assign fifo_count    = count_q;
    assign beat_count    = beat_count_q;
    assign packet_done   = packet_done_q;
    assign len_error     = len_error_q;
    assign rx_state_o    = state_q;
    assign S_AXIS_TREADY = tready;

endmodule

// File: tb/tb_axis_slave_rx.sv
// Directed self-checking bench for axis_slave_rx: framing, strobe masking,
// FIFO ordering/full/wrap behaviour, rx_clear and reset.
module tb_axis_slave_rx;

    logic        clk;
    logic        rst;
    logic        s_tready;
    logic [31:0] s_tdata;
    logic [3:0]  s_tstrb;
    logic        s_tlast;
    logic        s_tvalid;
    logic        rx_en;
    logic        rx_clear;
    logic [15:0] expected_beats;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        rd_last;
    logic        rd_valid;
    logic        fifo_empty;
    logic [4:0]  fifo_count;
    logic [15:0] beat_count;
    logic        packet_done;
    logic        len_error;
    logic [1:0]  rx_state;

    int checks = 0;
    int errors = 0;

    axis_slave_rx #(.FIFO_DEPTH(16), .C_S_AXIS_TDATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .S_AXIS_TREADY(s_tready), .S_AXIS_TDATA(s_tdata), .S_AXIS_TSTRB(s_tstrb),
        .S_AXIS_TLAST(s_tlast), .S_AXIS_TVALID(s_tvalid),
        .rx_en(rx_en), .rx_clear(rx_clear), .expected_beats(expected_beats),
        .rd_en(rd_en), .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid),
        .fifo_empty(fifo_empty), .fifo_count(fifo_count), .beat_count(beat_count),
        .packet_done(packet_done), .len_error(len_error), .rx_state_o(rx_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input logic [15:0] beats);
        expected_beats = beats;
        rx_en = 1'b1;
        tick();
    endtask

    task automatic drive_beat(input logic [31:0] d, input logic [3:0] strb, input logic last);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tstrb  = strb;
        s_tlast  = last;
    endtask

    task automatic clear_pulse();
        s_tvalid = 1'b0;
        rx_en    = 1'b0;
        rx_clear = 1'b1;
        tick();
        rx_clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %0b expected 0", s_tready); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %0b expected 0", rd_valid); end
        checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_fifo_empty: got %0b expected 1", fifo_empty); end
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL reset_fifo_count: got %0d expected 0", fifo_count); end
        checks++; if (beat_count !== 16'd0) begin errors++; $display("FAIL reset_beat_count: got %0d expected 0", beat_count); end
        checks++; if (packet_done !== 1'b0) begin errors++; $display("FAIL reset_packet_done: got %0b expected 0", packet_done); end
        checks++; if (len_error !== 1'b0) begin errors++; $display("FAIL reset_len_error: got %0b expected 0", len_error); end
        checks++; if (rx_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", rx_state); end
        checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
        checks++; if (rd_last !== 1'b0) begin errors++; $display("FAIL reset_rd_last: got %0b expected 0", rd_last); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_packet_4();
        arm(16'd4);
        for (int i = 0; i < 4; i++) begin
            drive_beat(32'h11111111 * (i + 1), 4'hF, (i == 3));
            #1;
            checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL pkt4_tready beat %0d: got %0b expected 1", i, s_tready); end
            tick();
        end
        s_tvalid = 1'b0;
        #1;
        checks++; if (packet_done !== 1'b1) begin errors++; $display("FAIL pkt4_done: got %0b expected 1", packet_done); end
        checks++; if (len_error !== 1'b0) begin errors++; $display("FAIL pkt4_len_error: got %0b expected 0", len_error); end
        checks++; if (rx_state !== 2'd2) begin errors++; $display("FAIL pkt4_state: got %0d expected 2", rx_state); end
        checks++; if (fifo_count !== 5'd4) begin errors++; $display("FAIL pkt4_count: got %0d expected 4", fifo_count); end
        checks++; if (beat_count !== 16'd4) begin errors++; $display("FAIL pkt4_beat_count: got %0d expected 4", beat_count); end
        checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL pkt4_tready_done: got %0b expected 0", s_tready); end
        tick();
        checks++; if (packet_done !== 1'b0) begin errors++; $display("FAIL pkt4_done_pulse: got %0b expected 0", packet_done); end
        checks++; if (rx_state !== 2'd2) begin errors++; $display("FAIL pkt4_state_hold: got %0d expected 2", rx_state); end
    endtask

    task automatic test_drain();
        logic [31:0] exp_d;
        for (int i = 0; i < 4; i++) begin
            exp_d = 32'h11111111 * (i + 1);
            checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL drain_valid %0d: got %0b expected 1", i, rd_valid); end
            checks++; if (rd_data !== exp_d) begin errors++; $display("FAIL drain_data %0d: got %h expected %h", i, rd_data, exp_d); end
            checks++; if (rd_last !== (i == 3)) begin errors++; $display("FAIL drain_last %0d: got %0b expected %0b", i, rd_last, (i == 3)); end
            checks++; if (fifo_count !== 5'(4 - i)) begin errors++; $display("FAIL drain_count %0d: got %0d expected %0d", i, fifo_count, 4 - i); end
            rd_en = 1'b1;
            tick();
        end
        tick();
        rd_en = 1'b0;
        checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %0b expected 1", fifo_empty); end
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL drain_underflow_count: got %0d expected 0", fifo_count); end
        checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL drain_rd_data_empty: got %h expected 0", rd_data); end
        checks++; if (rd_last !== 1'b0) begin errors++; $display("FAIL drain_rd_last_empty: got %0b expected 0", rd_last); end
        rx_en = 1'b0;
        tick();
        checks++; if (rx_state !== 2'd0) begin errors++; $display("FAIL drain_state_idle: got %0d expected 0", rx_state); end
    endtask

    task automatic test_strobe();
        arm(16'd1);
        drive_beat(32'hAABBCCDD, 4'b0101, 1'b1);
        tick();
        s_tvalid = 1'b0;
        checks++; if (packet_done !== 1'b1) begin errors++; $display("FAIL strb_done: got %0b expected 1", packet_done); end
        checks++; if (len_error !== 1'b0) begin errors++; $display("FAIL strb_len_error: got %0b expected 0", len_error); end
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL strb_valid: got %0b expected 1", rd_valid); end
        checks++; if (rd_data !== 32'h00BB00DD) begin errors++; $display("FAIL strb_data: got %h expected 00bb00dd", rd_data); end
        checks++; if (rd_last !== 1'b1) begin errors++; $display("FAIL strb_last: got %0b expected 1", rd_last); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        rx_en = 1'b0;
        tick();
    endtask

    task automatic test_early_last();
        arm(16'd8);
        for (int i = 0; i < 3; i++) begin
            drive_beat(32'hA0 + i, 4'hF, (i == 2));
            tick();
        end
        s_tvalid = 1'b0;
        checks++; if (packet_done !== 1'b1) begin errors++; $display("FAIL early_done: got %0b expected 1", packet_done); end
        checks++; if (len_error !== 1'b1) begin errors++; $display("FAIL early_len_error: got %0b expected 1", len_error); end
        checks++; if (beat_count !== 16'd3) begin errors++; $display("FAIL early_beat_count: got %0d expected 3", beat_count); end
        checks++; if (rx_state !== 2'd2) begin errors++; $display("FAIL early_state: got %0d expected 2", rx_state); end
        checks++; if (fifo_count !== 5'd3) begin errors++; $display("FAIL early_count: got %0d expected 3", fifo_count); end
        clear_pulse();
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL early_clear_count: got %0d expected 0", fifo_count); end
        checks++; if (rx_state !== 2'd0) begin errors++; $display("FAIL early_clear_state: got %0d expected 0", rx_state); end
        checks++; if (beat_count !== 16'd0) begin errors++; $display("FAIL early_clear_beats: got %0d expected 0", beat_count); end
    endtask

    task automatic test_late_last();
        arm(16'd2);
        for (int i = 0; i < 3; i++) begin
            drive_beat(32'hB0 + i, 4'hF, 1'b0);
            if (i < 2) tick();
        end
        #1;
        checks++; if (packet_done !== 1'b1) begin errors++; $display("FAIL late_done: got %0b expected 1", packet_done); end
        checks++; if (len_error !== 1'b1) begin errors++; $display("FAIL late_len_error: got %0b expected 1", len_error); end
        checks++; if (beat_count !== 16'd2) begin errors++; $display("FAIL late_beat_count: got %0d expected 2", beat_count); end
        checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL late_tready: got %0b expected 0", s_tready); end
        tick();
        checks++; if (fifo_count !== 5'd2) begin errors++; $display("FAIL late_count_held: got %0d expected 2", fifo_count); end
        checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL late_tready_held: got %0b expected 0", s_tready); end
        checks++; if (len_error !== 1'b0) begin errors++; $display("FAIL late_len_error_pulse: got %0b expected 0", len_error); end
        clear_pulse();
    endtask

    task automatic test_full_and_clear();
        int n;
        logic [31:0] exp_d;
        n = 0;
        arm(16'd0);
        for (int c = 0; c < 20; c++) begin
            drive_beat(32'h100 + n, 4'hF, 1'b0);
            #1;
            if (s_tready) n++;
            tick();
        end
        checks++; if (n !== 16) begin errors++; $display("FAIL full_accepts: got %0d expected 16", n); end
        checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL full_count: got %0d expected 16", fifo_count); end
        checks++; if (beat_count !== 16'd16) begin errors++; $display("FAIL full_beat_count: got %0d expected 16", beat_count); end
        rd_en = 1'b1;
        #1;
        checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL full_pop_tready: got %0b expected 0", s_tready); end
        checks++; if (rd_data !== 32'h100) begin errors++; $display("FAIL full_head: got %h expected 00000100", rd_data); end
        tick();
        rd_en = 1'b0;
        #1;
        checks++; if (fifo_count !== 5'd15) begin errors++; $display("FAIL full_after_pop: got %0d expected 15", fifo_count); end
        checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL full_tready_reopen: got %0b expected 1", s_tready); end
        tick();
        s_tvalid = 1'b0;
        checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL full_refill: got %0d expected 16", fifo_count); end
        checks++; if (beat_count !== 16'd17) begin errors++; $display("FAIL full_beat_count17: got %0d expected 17", beat_count); end
        for (int i = 0; i < 16; i++) begin
            exp_d = 32'h101 + i;
            checks++; if (rd_data !== exp_d) begin errors++; $display("FAIL wrap_order %0d: got %h expected %h", i, rd_data, exp_d); end
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
        checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %0b expected 1", fifo_empty); end
        drive_beat(32'h200, 4'hF, 1'b0);
        tick();
        drive_beat(32'h201, 4'hF, 1'b0);
        tick();
        checks++; if (fifo_count !== 5'd2) begin errors++; $display("FAIL clear_pre_count: got %0d expected 2", fifo_count); end
        drive_beat(32'h202, 4'hF, 1'b0);
        rx_clear = 1'b1;
        #1;
        checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL clear_tready: got %0b expected 0", s_tready); end
        tick();
        rx_clear = 1'b0;
        s_tvalid = 1'b0;
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL clear_count: got %0d expected 0", fifo_count); end
        checks++; if (rx_state !== 2'd0) begin errors++; $display("FAIL clear_state: got %0d expected 0", rx_state); end
        checks++; if (beat_count !== 16'd0) begin errors++; $display("FAIL clear_beats: got %0d expected 0", beat_count); end
        checks++; if (packet_done !== 1'b0) begin errors++; $display("FAIL clear_no_done: got %0b expected 0", packet_done); end
        checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL clear_empty: got %0b expected 1", fifo_empty); end
        rx_en = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_packet();
        arm(16'd4);
        drive_beat(32'hC0, 4'hF, 1'b0);
        tick();
        drive_beat(32'hC1, 4'hF, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (rx_state !== 2'd0) begin errors++; $display("FAIL rstmid_state: got %0d expected 0", rx_state); end
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL rstmid_count: got %0d expected 0", fifo_count); end
        checks++; if (beat_count !== 16'd0) begin errors++; $display("FAIL rstmid_beats: got %0d expected 0", beat_count); end
        checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL rstmid_tready: got %0b expected 0", s_tready); end
        s_tvalid = 1'b0;
        rx_en = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        s_tdata = '0;
        s_tstrb = '0;
        s_tlast = 1'b0;
        s_tvalid = 1'b0;
        rx_en = 1'b0;
        rx_clear = 1'b0;
        expected_beats = '0;
        rd_en = 1'b0;
        test_reset();
        test_packet_4();
        test_drain();
        test_strobe();
        test_early_last();
        test_late_last();
        test_full_and_clear();
        test_reset_mid_packet();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
